// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the memory bus arbiter slice.
// Policy selection in the arbiter is controlled by the ARB_ROUND_ROBIN_EN macro.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam int BUS_DATA_WIDTH_DEF = 64;
    localparam int BUS_TAG_WIDTH_DEF  = 13;

    // Index of the set bit of a one-hot vector of up to 8 requesters.
    function automatic int unsigned onehot_to_idx(input logic [7:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select for the bus arbiter.
// ARB_ROUND_ROBIN_EN defined: round-robin after ptr; undefined: highest index wins.
module arb_pick
    import mem_bus_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
`ifdef ARB_ROUND_ROBIN_EN
    input  logic [IDX_W-1:0]   ptr,
`endif
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] win,
    output logic [IDX_W-1:0]   win_idx
);

    int         best;
    logic [7:0] win_ext;

`ifdef ARB_ROUND_ROBIN_EN
    int best_dist;
    int dist;

    // Distance of each requester from the slot just after the pointer; nearest wins.
    always_comb begin
        best      = 0;
        best_dist = NUM_REQ;
        dist      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            dist = (i + NUM_REQ - 1 - int'(ptr)) % NUM_REQ;
            if (req[i] && (dist < best_dist)) begin
                best_dist = dist;
                best      = i;
            end
        end
    end
`else
    always_comb begin
        best = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i]) best = i;
        end
    end
`endif

    always_comb begin
        win = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win[i] = req[i] && (i == best);
        end
    end

    always_comb begin
        win_ext                = '0;
        win_ext[NUM_REQ-1:0]   = win;
    end

    assign win_idx = IDX_W'(onehot_to_idx(win_ext));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Grants one cache client at a time exclusive use of the shared memory bus.
// Selection policy: round-robin with ARB_ROUND_ROBIN_EN defined, else fixed priority.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int BUS_DATA_WIDTH = BUS_DATA_WIDTH_DEF,
    parameter int BUS_TAG_WIDTH  = BUS_TAG_WIDTH_DEF,
    parameter int OWNER_W        = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                cl_busreq,
    input  logic [NUM_REQ-1:0]                cl_busidle,
    output logic [NUM_REQ-1:0]                cl_busgrant,
    input  logic [NUM_REQ-1:0]                cl_reqcyc,
    input  logic [NUM_REQ*BUS_DATA_WIDTH-1:0] cl_req,
    input  logic [NUM_REQ*BUS_TAG_WIDTH-1:0]  cl_reqtag,
    output logic [NUM_REQ-1:0]                cl_reqack,
    output logic [NUM_REQ-1:0]                cl_respcyc,
    output logic [BUS_DATA_WIDTH-1:0]         cl_resp,
    output logic [BUS_TAG_WIDTH-1:0]          cl_resptag,
    input  logic [NUM_REQ-1:0]                cl_respack,
    output logic                              bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0]         bus_req,
    output logic [BUS_TAG_WIDTH-1:0]          bus_reqtag,
    input  logic                              bus_reqack,
    input  logic                              bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0]         bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]          bus_resptag,
    output logic                              bus_respack,
    output logic [OWNER_W-1:0]                owner,
    output logic                              busy
);

    arb_state_e         state, state_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [OWNER_W-1:0] owner_nxt;
    logic [NUM_REQ-1:0] win;
    logic [OWNER_W-1:0] win_idx;
    logic               grant_valid;
    logic               owner_done;

`ifdef ARB_ROUND_ROBIN_EN
    logic [OWNER_W-1:0] rr_ptr, rr_ptr_nxt;
`endif

    arb_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (OWNER_W)
    ) u_pick (
`ifdef ARB_ROUND_ROBIN_EN
        .ptr     (rr_ptr),
`endif
        .req     (cl_busreq),
        .win     (win),
        .win_idx (win_idx)
    );

    assign grant_valid = |cl_busgrant;
    // The grant vector is one-hot on the owner, so masking with it selects cl_busidle[owner].
    assign owner_done  = |(cl_busidle & cl_busgrant);
    assign busy        = (state == GRANT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cl_busgrant <= '0;
            owner       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr      <= OWNER_W'(NUM_REQ - 1);
`endif
        end else begin
            state       <= state_nxt;
            cl_busgrant <= grant_nxt;
            owner       <= owner_nxt;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr      <= rr_ptr_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_nxt  = cl_busgrant;
        owner_nxt  = owner;
`ifdef ARB_ROUND_ROBIN_EN
        rr_ptr_nxt = rr_ptr;
`endif
        case (state)
            IDLE: begin
                if (|cl_busreq) begin
                    state_nxt  = GRANT;
                    grant_nxt  = win;
                    owner_nxt  = win_idx;
`ifdef ARB_ROUND_ROBIN_EN
                    rr_ptr_nxt = win_idx;
`endif
                end
            end
            GRANT: begin
                // A release request is deferred while a response is still on the bus.
                if (owner_done && !bus_respcyc) begin
                    state_nxt = RELEASE;
                    grant_nxt = '0;
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_comb begin
        bus_req    = '0;
        bus_reqtag = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cl_busgrant[i]) begin
                bus_req    = cl_req[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
                bus_reqtag = cl_reqtag[i*BUS_TAG_WIDTH +: BUS_TAG_WIDTH];
            end
        end
    end

    assign bus_reqcyc  = |(cl_reqcyc & cl_busgrant);
    assign bus_respack = |(cl_respack & cl_busgrant);
    assign cl_reqack   = cl_busgrant & {NUM_REQ{bus_reqack}};
    assign cl_respcyc  = cl_busgrant & {NUM_REQ{bus_respcyc}};
    assign cl_resp     = grant_valid ? bus_resp : '0;
    assign cl_resptag  = grant_valid ? bus_resptag : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter; expectations follow ARB_ROUND_ROBIN_EN when defined.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

    localparam int N  = 2;
    localparam int DW = 64;
    localparam int TW = 13;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    cl_busreq = '0;
    logic [N-1:0]    cl_busidle = '0;
    logic [N-1:0]    cl_busgrant;
    logic [N-1:0]    cl_reqcyc = '0;
    logic [N*DW-1:0] cl_req = '0;
    logic [N*TW-1:0] cl_reqtag = '0;
    logic [N-1:0]    cl_reqack;
    logic [N-1:0]    cl_respcyc;
    logic [DW-1:0]   cl_resp;
    logic [TW-1:0]   cl_resptag;
    logic [N-1:0]    cl_respack = '0;
    logic            bus_reqcyc;
    logic [DW-1:0]   bus_req;
    logic [TW-1:0]   bus_reqtag;
    logic            bus_reqack = 1'b0;
    logic            bus_respcyc = 1'b0;
    logic [DW-1:0]   bus_resp = '0;
    logic [TW-1:0]   bus_resptag = '0;
    logic            bus_respack;
    logic [0:0]      owner;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    mem_bus_arbiter #(
        .NUM_REQ        (N),
        .BUS_DATA_WIDTH (DW),
        .BUS_TAG_WIDTH  (TW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cl_busreq   (cl_busreq),
        .cl_busidle  (cl_busidle),
        .cl_busgrant (cl_busgrant),
        .cl_reqcyc   (cl_reqcyc),
        .cl_req      (cl_req),
        .cl_reqtag   (cl_reqtag),
        .cl_reqack   (cl_reqack),
        .cl_respcyc  (cl_respcyc),
        .cl_resp     (cl_resp),
        .cl_resptag  (cl_resptag),
        .cl_respack  (cl_respack),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .bus_respack (bus_respack),
        .owner       (owner),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: a client holds the bus for a tenure, then two idle cycles pass before the next pick.
    int m_owner = 0;
    bit m_held  = 1'b0;
    int m_gap   = 0;
`ifdef ARB_ROUND_ROBIN_EN
    int m_last  = N - 1;
`endif

    function automatic int pick(input logic [N-1:0] r);
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            if (r[(m_last + k) % N]) return (m_last + k) % N;
        end
`else
        for (int i = N - 1; i >= 0; i--) begin
            if (r[i]) return i;
        end
`endif
        return 0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_owner <= 0;
            m_held  <= 1'b0;
            m_gap   <= 0;
`ifdef ARB_ROUND_ROBIN_EN
            m_last  <= N - 1;
`endif
        end else if (m_held) begin
            if (cl_busidle[m_owner] && !bus_respcyc) begin
                m_held <= 1'b0;
                m_gap  <= 1;
            end
        end else if (m_gap > 0) begin
            m_gap <= m_gap - 1;
        end else if (cl_busreq != '0) begin
            m_owner <= pick(cl_busreq);
            m_held  <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            m_last  <= pick(cl_busreq);
`endif
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [N-1:0] eg;
            eg = '0;
            if (m_held) eg[m_owner] = 1'b1;
            check("cmp_grant", 64'(cl_busgrant), 64'(eg));
            check("cmp_busy", 64'(busy), 64'(m_held));
            check("cmp_owner", 64'(owner), 64'(m_owner));
            check("cmp_bus_reqcyc", 64'(bus_reqcyc), 64'(m_held && cl_reqcyc[m_owner]));
            check("cmp_bus_req", bus_req, m_held ? cl_req[m_owner*DW +: DW] : 64'd0);
            check("cmp_bus_reqtag", 64'(bus_reqtag), m_held ? 64'(cl_reqtag[m_owner*TW +: TW]) : 64'd0);
            check("cmp_reqack", 64'(cl_reqack), bus_reqack ? 64'(eg) : 64'd0);
            check("cmp_respcyc", 64'(cl_respcyc), bus_respcyc ? 64'(eg) : 64'd0);
            check("cmp_resp", cl_resp, m_held ? bus_resp : 64'd0);
            check("cmp_resptag", 64'(cl_resptag), m_held ? 64'(bus_resptag) : 64'd0);
            check("cmp_respack", 64'(bus_respack), 64'(m_held && cl_respack[m_owner]));
        end
    end

    logic [N-1:0] exp_tenure [4];
    logic [N-1:0] g;
    int           waited;

    initial begin
        cl_req    = {64'h1111_2222_3333_4444, 64'h0000_0000_DEAD_BEEF};
        cl_reqtag = {13'h1B1, 13'h0A0};
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        check("reset_grant", 64'(cl_busgrant), 64'd0);
        check("reset_owner", 64'(owner), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_bus_reqcyc", 64'(bus_reqcyc), 64'd0);

        // Single request from the i-cache.
        reset     = 1'b0;
        cl_busreq = 2'b01;
        cl_reqcyc = 2'b01;
        tick();
        check("single_grant", 64'(cl_busgrant), 64'h1);
        check("single_busy", 64'(busy), 64'h1);
        check("single_bus_req", bus_req, 64'hDEAD_BEEF);
        check("single_bus_reqtag", 64'(bus_reqtag), 64'h0A0);
        cl_busreq = 2'b00;
        tick();
        check("hold_after_busreq_drop", 64'(cl_busgrant), 64'h1);

        // Response steering to owner 0.
        bus_respcyc = 1'b1;
        bus_resptag = 13'h0A5;
        bus_resp    = 64'hCAFE_F00D_0000_0001;
        cl_respack  = 2'b10;
        bus_reqack  = 1'b1;
        #1;
        check("steer_respcyc", 64'(cl_respcyc), 64'h1);
        check("steer_resptag", 64'(cl_resptag), 64'h0A5);
        check("steer_respack_nonowner", 64'(bus_respack), 64'h0);
        check("steer_reqack", 64'(cl_reqack), 64'h1);

        // busidle during a response phase is deferred.
        cl_busidle = 2'b01;
        tick();
        check("idle_during_resp_held", 64'(cl_busgrant), 64'h1);
        bus_respcyc = 1'b0;
        bus_reqack  = 1'b0;
        cl_respack  = 2'b00;
        tick();
        check("release_grant", 64'(cl_busgrant), 64'h0);
        check("release_busy", 64'(busy), 64'h0);
        cl_busidle = 2'b00;
        cl_reqcyc  = 2'b00;
        tick();

        // Simultaneous requests straight after reset.
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        cl_busreq = 2'b11;
        tick();
`ifdef ARB_ROUND_ROBIN_EN
        check("simul_first", 64'(cl_busgrant), 64'h1);
`else
        check("simul_first", 64'(cl_busgrant), 64'h2);
`endif
        cl_busidle = 2'b11;
        tick();
        check("simul_turnaround", 64'(cl_busgrant), 64'h0);
        cl_busidle = 2'b00;
        tick();
        check("simul_idle_gap", 64'(cl_busgrant), 64'h0);
        tick();
        check("simul_second", 64'(cl_busgrant), 64'h2);

        // Release timing with client 0 waiting behind owner 1.
        cl_busreq   = 2'b01;
        cl_busidle  = 2'b10;
        bus_respcyc = 1'b1;
        tick();
        check("rt_held_by_resp", 64'(cl_busgrant), 64'h2);
        bus_respcyc = 1'b0;
        tick();
        check("rt_dead_cycle", 64'(cl_busgrant), 64'h0);
        cl_busidle = 2'b00;
        tick();
        check("rt_idle_cycle", 64'(cl_busgrant), 64'h0);
        tick();
        check("rt_next_grant", 64'(cl_busgrant), 64'h1);
        check("rt_next_owner", 64'(owner), 64'h0);

        // Reset while owner 1 drives the bus.
        cl_busreq  = 2'b10;
        cl_busidle = 2'b01;
        tick();
        cl_busidle = 2'b00;
        tick();
        tick();
        cl_reqcyc = 2'b10;
        #1;
        check("mid_grant", 64'(cl_busgrant), 64'h2);
        check("mid_bus_reqcyc", 64'(bus_reqcyc), 64'h1);
        check("mid_bus_req", bus_req, 64'h1111_2222_3333_4444);
        check("mid_bus_reqtag", 64'(bus_reqtag), 64'h1B1);
        reset     = 1'b1;
        cl_busreq = 2'b00;
        tick();
        check("rst_mid_grant", 64'(cl_busgrant), 64'h0);
        check("rst_mid_bus_reqcyc", 64'(bus_reqcyc), 64'h0);
        check("rst_mid_owner", 64'(owner), 64'h0);
        check("rst_mid_busy", 64'(busy), 64'h0);
        reset     = 1'b0;
        cl_reqcyc = 2'b00;

        // Both clients keep requesting; each owner releases after three cycles.
`ifdef ARB_ROUND_ROBIN_EN
        exp_tenure = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_tenure = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
        cl_busreq = 2'b11;
        for (int t = 0; t < 4; t++) begin
            waited = 0;
            tick();
            while (cl_busgrant == '0 && waited < 8) begin
                tick();
                waited++;
            end
            g = cl_busgrant;
            check($sformatf("tenure_%0d", t), 64'(g), 64'(exp_tenure[t]));
            tick();
            tick();
            cl_busidle = g;
            tick();
            cl_busidle = 2'b00;
        end
        cl_busreq = 2'b00;
        tick();
        tick();
        tick();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
